// File: rtl/seven_segment_capture_if.sv
// Output-side handshake bundle of seven_segment_capture: one decoded
// frame per valid/ready transfer, plus per-digit blank and error flags.
interface seven_segment_capture_if;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [5:0]  out_blank;
    logic [5:0]  out_err;

    modport master (
        output out_valid,
        output out_data,
        output out_blank,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_blank,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: samples six active-low 7-segment buses, debounces
// each digit, decodes them to hex nibbles and hands every new stable frame
// to the consumer over a valid/ready handshake.
// Optional macro SEVSEG_CAPTURE_ERRCNT_EN enables the saturating counter of
// delivered frames carrying an illegal digit; otherwise err_count is zero.
module seven_segment_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  HEX0,
    input  logic [6:0]  HEX1,
    input  logic [6:0]  HEX2,
    input  logic [6:0]  HEX3,
    input  logic [6:0]  HEX4,
    input  logic [6:0]  HEX5,
    input  logic        rescan,
    output logic [15:0] err_count,
    seven_segment_capture_if.master bus
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    typedef enum logic {
        SETTLE  = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Returns {blank, err, nibble} for one active-low segment pattern (g..a).
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b00_0000;
        case (seg)
            7'b1000000: r = 6'h0;
            7'b1111001: r = 6'h1;
            7'b0100100: r = 6'h2;
            7'b0110000: r = 6'h3;
            7'b0011001: r = 6'h4;
            7'b0010010: r = 6'h5;
            7'b0000010: r = 6'h6;
            7'b1111000: r = 6'h7;
            7'b0000000: r = 6'h8;
            7'b0010000: r = 6'h9;
            7'b0001000: r = 6'hA;
            7'b0000011: r = 6'hB;
            7'b1000110: r = 6'hC;
            7'b0100001: r = 6'hD;
            7'b0000110: r = 6'hE;
            7'b0001110: r = 6'hF;
            7'b1111111: r = 6'b10_0000;
            default:    r = 6'b01_0000;
        endcase
        return r;
    endfunction

    logic [41:0] hex_in;
    logic [41:0] frame_next;     // debounced patterns as they will be after this edge
    logic [5:0]  digit_stable;
    logic [23:0] dec_data;
    logic [5:0]  dec_blank;
    logic [5:0]  dec_err;

    assign hex_in = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        logic [6:0] s_hex_reg;
        logic [6:0] prev_reg;
        logic [6:0] prev_next;
        logic [7:0] cnt_reg;
        logic [7:0] cnt_next;

        // Input sample plus debounce history for this digit.
        always_ff @(posedge clk) begin
            if (reset) begin
                s_hex_reg <= 7'h7F;
                prev_reg  <= 7'h7F;
                cnt_reg   <= 8'd0;
            end else begin
                s_hex_reg <= hex_in[gi*7 +: 7];
                prev_reg  <= prev_next;
                cnt_reg   <= cnt_next;
            end
        end

        // Restart the count on any change, otherwise count up to the threshold.
        always_comb begin
            prev_next = prev_reg;
            cnt_next  = cnt_reg;
            if (s_hex_reg != prev_reg) begin
                prev_next = s_hex_reg;
                cnt_next  = 8'd1;
            end else if (cnt_reg != STABLE_CNT) begin
                cnt_next = cnt_reg + 8'd1;
            end
        end

        // Stability is judged on the post-edge values so the frame is taken on
        // the same edge that completes the count.
        assign digit_stable[gi]       = (cnt_next == STABLE_CNT);
        assign frame_next[gi*7 +: 7]  = prev_next;
        assign {dec_blank[gi], dec_err[gi], dec_data[gi*4 +: 4]} = decode_seg(prev_next);
    end

    state_t      state_reg;
    state_t      state_next;
    logic        load;
    logic        handshake;
    logic        frame_stable;
    logic        rescan_pending_reg;
    logic [41:0] held_frame_reg;
    logic [41:0] last_delivered_reg;
    logic [23:0] out_data_reg;
    logic [5:0]  out_blank_reg;
    logic [5:0]  out_err_reg;

    assign frame_stable = &digit_stable;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SETTLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: take a frame when it is stable and new (or requested),
    // release it on the handshake.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            SETTLE: begin
                if (frame_stable &&
                    ((frame_next != last_delivered_reg) || rescan_pending_reg)) begin
                    load       = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    handshake  = 1'b1;
                    state_next = SETTLE;
                end
            end
            default: state_next = SETTLE;
        endcase
    end

    // Captured frame, delivery history and the pending rescan request.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg       <= 24'h0;
            out_blank_reg      <= 6'h0;
            out_err_reg        <= 6'h0;
            held_frame_reg     <= {42{1'b1}};
            last_delivered_reg <= {42{1'b1}};
            rescan_pending_reg <= 1'b0;
        end else begin
            if (load) begin
                out_data_reg   <= dec_data;
                out_blank_reg  <= dec_blank;
                out_err_reg    <= dec_err;
                held_frame_reg <= frame_next;
            end
            if (handshake) begin
                last_delivered_reg <= held_frame_reg;
            end
            // A request arriving on the handshake cycle is kept for the next frame.
            if (rescan) begin
                rescan_pending_reg <= 1'b1;
            end else if (handshake) begin
                rescan_pending_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (state_reg == PRESENT);
    assign bus.out_data  = out_data_reg;
    assign bus.out_blank = out_blank_reg;
    assign bus.out_err   = out_err_reg;

`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    logic [15:0] err_count_reg;

    // Count delivered frames that carried at least one illegal digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg <= 16'h0000;
        end else if (handshake && (out_err_reg != 6'h0) && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'h0001;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomized self-checking bench for seven_segment_capture. Expected frames
// come from a table lookup of the segment patterns and a model of which raw
// frame was last handed over.
module tb_seven_segment_capture;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rescan = 1'b0;
    logic [6:0]  hex [6];
    logic [15:0] err_count;

    seven_segment_capture_if bus();

    seven_segment_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .reset     (reset),
        .HEX0      (hex[0]),
        .HEX1      (hex[1]),
        .HEX2      (hex[2]),
        .HEX3      (hex[3]),
        .HEX4      (hex[4]),
        .HEX5      (hex[5]),
        .rescan    (rescan),
        .err_count (err_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [41:0] last_del = {42{1'b1}};
    int          exp_errcnt = 0;

    // Reference decode: {err[5:0], blank[5:0], data[23:0]}.
    function automatic logic [35:0] ref_decode(input logic [41:0] f);
        logic [23:0] d;
        logic [5:0]  b;
        logic [5:0]  e;
        logic [6:0]  seg;
        bit          found;
        d = '0; b = '0; e = '0;
        for (int i = 0; i < 6; i++) begin
            seg = f[i*7 +: 7];
            found = 1'b0;
            for (int v = 0; v < 16; v++) begin
                if (seg_tab[v] == seg) begin
                    d[i*4 +: 4] = 4'(v);
                    found = 1'b1;
                end
            end
            if (!found) begin
                if (seg == 7'h7F) b[i] = 1'b1;
                else              e[i] = 1'b1;
            end
        end
        return {e, b, d};
    endfunction

    function automatic logic [41:0] rand_frame(input bit legal_only);
        logic [41:0] f;
        int r;
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 9);
            if (legal_only || r < 8) f[i*7 +: 7] = seg_tab[$urandom_range(0, 15)];
            else if (r == 8)         f[i*7 +: 7] = 7'h7F;
            else                     f[i*7 +: 7] = 7'($urandom);
        end
        return f;
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
        return 16'(exp_errcnt);
`else
        return 16'h0000;
`endif
    endfunction

    // Model of a completed transfer.
    task automatic model_commit(input logic [41:0] f);
        logic [35:0] x;
        x = ref_decode(f);
        last_del = f;
        if (x[35:30] != 6'h0 && exp_errcnt < 65535) exp_errcnt++;
    endtask

    task automatic apply_frame(input logic [41:0] f);
        for (int i = 0; i < 6; i++) hex[i] = f[i*7 +: 7];
    endtask

    // Stimulus/observation: drive a frame, measure edges to out_valid, hold,
    // handshake, then watch for re-issue.
    task automatic run_frame(input logic [41:0] f, input int hold,
                             output int lat, output logic [23:0] d,
                             output logic [5:0] b, output logic [5:0] e,
                             output bit held_ok, output bit drop_ok, output bit idle_ok);
        apply_frame(f);
        lat = 0;
        @(posedge clk); #1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.out_data; b = bus.out_blank; e = bus.out_err;
        held_ok = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== d || bus.out_blank !== b || bus.out_err !== e)
                held_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drop_ok = !bus.out_valid;
        idle_ok = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid) idle_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        bit quiet;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) hex[i] = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h want 000000", bus.out_data); end
        n_cmp++; if (bus.out_blank !== 6'h0) begin n_bad++; $display("FAIL reset_blank: got %b want 000000", bus.out_blank); end
        n_cmp++; if (bus.out_err !== 6'h0) begin n_bad++; $display("FAIL reset_err: got %b want 000000", bus.out_err); end
        n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
        reset = 1'b0;
        bus.out_ready = 1'b1;   // ready while nothing is offered must be harmless
        quiet = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.out_valid) quiet = 1'b0;
        end
        bus.out_ready = 1'b0;
        n_cmp++; if (!quiet) begin n_bad++; $display("FAIL blank_idle: got valid=1 want 0 for 50 cycles"); end
        $display("test_reset done");
    endtask

    task automatic test_first_frame();
        logic [41:0] f;
        logic [35:0] x;
        int lat; logic [23:0] d; logic [5:0] b, e; bit h, dr, id;
        for (int i = 0; i < 6; i++) f[i*7 +: 7] = seg_tab[i+1];
        x = ref_decode(f);
        run_frame(f, 10, lat, d, b, e, h, dr, id);
        model_commit(f);
        n_cmp++; if (lat !== STABLE) begin n_bad++; $display("FAIL first_latency: got %0d want %0d", lat, STABLE); end
        n_cmp++; if (d !== 24'h654321 || d !== x[23:0]) begin n_bad++; $display("FAIL first_data: got %h want 654321", d); end
        n_cmp++; if (b !== x[29:24] || e !== x[35:30]) begin n_bad++; $display("FAIL first_flags: got blank=%b err=%b want 000000/000000", b, e); end
        n_cmp++; if (!h) begin n_bad++; $display("FAIL first_hold: got unstable output want held 10 cycles"); end
        n_cmp++; if (!dr) begin n_bad++; $display("FAIL first_drop: got valid=1 want 0 after handshake"); end
        n_cmp++; if (!id) begin n_bad++; $display("FAIL first_reissue: got repeat frame want idle"); end
        $display("frame %h delivered latency=%0d", d, lat);
    endtask

    task automatic test_glitch();
        logic [6:0] keep;
        bit quiet;
        keep = hex[2];
        hex[2] = seg_tab[8];
        repeat (2) @(posedge clk);
        #1;
        hex[2] = keep;
        quiet = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid) quiet = 1'b0;
        end
        n_cmp++; if (!quiet) begin n_bad++; $display("FAIL glitch: got valid=1 want no frame"); end
        $display("glitch on HEX2 for 2 cycles checked");
    endtask

    task automatic test_illegal();
        logic [41:0] f;
        int lat; logic [23:0] d; logic [5:0] b, e; bit h, dr, id;
        for (int i = 0; i < 6; i++) f[i*7 +: 7] = seg_tab[0];
        f[3*7 +: 7] = 7'b0101010;
        run_frame(f, 2, lat, d, b, e, h, dr, id);
        model_commit(f);
        n_cmp++; if (e !== 6'b001000) begin n_bad++; $display("FAIL illegal_err: got %b want 001000", e); end
        n_cmp++; if (d !== 24'h0 || b !== 6'h0) begin n_bad++; $display("FAIL illegal_data: got %h/%b want 000000/000000", d, b); end
        n_cmp++; if (!dr || !id) begin n_bad++; $display("FAIL illegal_handshake: got drop=%b idle=%b want 1/1", dr, id); end
        n_cmp++; if (err_count !== exp_cnt()) begin n_bad++; $display("FAIL illegal_errcnt: got %0d want %0d", err_count, exp_cnt()); end
        $display("illegal frame err=%b err_count=%0d", e, err_count);
    endtask

    task automatic test_rescan();
        logic [35:0] x;
        int w; bit quiet;
        x = ref_decode(last_del);
        rescan = 1'b1;
        @(posedge clk); #1;
        rescan = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++; if (!bus.out_valid) begin n_bad++; $display("FAIL rescan_valid: got 0 want 1 within 20 cycles"); end
        n_cmp++; if (bus.out_data !== x[23:0] || bus.out_err !== x[35:30] || bus.out_blank !== x[29:24])
            begin n_bad++; $display("FAIL rescan_data: got %h want %h", bus.out_data, x[23:0]); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        model_commit(last_del);
        quiet = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid) quiet = 1'b0;
        end
        n_cmp++; if (!quiet) begin n_bad++; $display("FAIL rescan_once: got second frame want idle"); end
        n_cmp++; if (err_count !== exp_cnt()) begin n_bad++; $display("FAIL rescan_errcnt: got %0d want %0d", err_count, exp_cnt()); end
        $display("rescan redelivered %h", x[23:0]);
    endtask

    task automatic test_random();
        logic [41:0] f;
        logic [35:0] x;
        int lat; logic [23:0] d; logic [5:0] b, e; bit h, dr, id, quiet;
        for (int it = 0; it < 12; it++) begin
            f = rand_frame(1'b0);
            x = ref_decode(f);
            if (f == last_del) begin
                apply_frame(f);
                quiet = 1'b1;
                repeat (15) begin
                    @(posedge clk); #1;
                    if (bus.out_valid) quiet = 1'b0;
                end
                n_cmp++; if (!quiet) begin n_bad++; $display("FAIL rand_same[%0d]: got valid=1 want idle", it); end
                $display("random %0d unchanged frame, no delivery", it);
            end else begin
                run_frame(f, $urandom_range(0, 5), lat, d, b, e, h, dr, id);
                model_commit(f);
                n_cmp++; if (lat !== STABLE || d !== x[23:0] || b !== x[29:24] || e !== x[35:30] || !h || !dr || !id)
                    begin n_bad++; $display("FAIL rand[%0d]: got lat=%0d data=%h blank=%b err=%b hold=%b drop=%b idle=%b want lat=%0d data=%h blank=%b err=%b",
                        it, lat, d, b, e, h, dr, id, STABLE, x[23:0], x[29:24], x[35:30]); end
                n_cmp++; if (err_count !== exp_cnt()) begin n_bad++; $display("FAIL rand_errcnt[%0d]: got %0d want %0d", it, err_count, exp_cnt()); end
                $display("random %0d data=%h blank=%b err=%b", it, d, b, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [41:0] fa, fb;
        logic [35:0] xa, xb;
        int w; bit h;
        fa = rand_frame(1'b1);
        if (fa == last_del) fa[6:0] = (fa[6:0] == seg_tab[0]) ? seg_tab[1] : seg_tab[0];
        fb = fa;
        fb[6:0] = (fa[6:0] == seg_tab[0]) ? seg_tab[1] : seg_tab[0];
        xa = ref_decode(fa);
        xb = ref_decode(fb);
        apply_frame(fa);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        apply_frame(fb);   // change inputs while the first frame is on offer
        h = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== xa[23:0]) h = 1'b0;
        end
        n_cmp++; if (!h) begin n_bad++; $display("FAIL b2b_hold: got data=%h want %h held", bus.out_data, xa[23:0]); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        model_commit(fa);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got valid=%b want 0", bus.out_valid); end
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++; if (!bus.out_valid || bus.out_data !== xb[23:0]) begin n_bad++; $display("FAIL b2b_second: got valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, xb[23:0]); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        model_commit(fb);
        $display("back-to-back %h then %h", xa[23:0], xb[23:0]);
    endtask

    task automatic test_reset_present();
        logic [41:0] f;
        logic [35:0] x;
        int w, lat;
        for (int i = 0; i < 6; i++) f[i*7 +: 7] = seg_tab[15-i];
        if (f == last_del) f[6:0] = seg_tab[3];
        x = ref_decode(f);
        apply_frame(f);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++; if (!bus.out_valid) begin n_bad++; $display("FAIL rstp_pre: got valid=0 want 1"); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstp_valid: got %b want 0", bus.out_valid); end
        reset = 1'b0;
        last_del = {42{1'b1}};
        exp_errcnt = 0;
        lat = 0;
        @(posedge clk); #1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== STABLE) begin n_bad++; $display("FAIL rstp_latency: got %0d want %0d", lat, STABLE); end
        n_cmp++; if (bus.out_data !== x[23:0]) begin n_bad++; $display("FAIL rstp_data: got %h want %h", bus.out_data, x[23:0]); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        model_commit(f);
        n_cmp++; if (err_count !== exp_cnt()) begin n_bad++; $display("FAIL rstp_errcnt: got %0d want %0d", err_count, exp_cnt()); end
        $display("reset during PRESENT, redelivered %h latency=%0d", x[23:0], lat);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_first_frame();
        test_glitch();
        test_illegal();
        test_rescan();
        test_random();
        test_back_to_back();
        test_reset_present();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the board seven-segment driver: samples six active-low 7-segment digit buses (HEX0..HEX5) and decodes each back to a hex nibble.
- Debounces each digit and flags blank or illegal patterns.
- Delivers each new stable frame as a 24-bit value over a valid/ready handshake.
- Used in loopback self-test and in Verilator benches to read back what the display logic drives.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit counts as stable; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- HEX0..HEX5  input  7 each  segment buses, active-low; bit0=a .. bit6=g
- rescan  input  1  single-cycle pulse; forces delivery of the next stable frame even if unchanged
- out_valid  output  1  frame available
- out_ready  input  1  consumer accepts frame
- out_data  output  24  decoded nibbles; [3:0]=HEX0 .. [23:20]=HEX5
- out_blank  output  6  bit i set when HEXi = 7'b1111111
- out_err  output  6  bit i set when HEXi is neither a legal digit nor blank
- err_count  output  16  illegal-frame counter (see Optional Feature)

Behaviour:
- All state is reset synchronously while reset=1. Reset values:
  - out_valid=0, out_data=0, out_blank=0, out_err=0, err_count=0
  - per-digit counters=0, input sample registers=7'h7F
  - last_delivered frame = all 7'h7F; rescan_pending=0
- Input stage: each HEXi is registered once (s_hex_i).
- Per-digit debounce, each cycle:
  - If s_hex_i differs from prev_i: prev_i <= s_hex_i, cnt_i <= 1.
  - Else: cnt_i increments, saturating at STABLE_CYCLES.
  - Digit is stable when cnt_i == STABLE_CYCLES.
- Frame is stable when all six digits are stable.
- Decode of prev_i (0..F):
  - 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000
  - 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110
  - 1111111: nibble 0, blank bit set.
  - Any other pattern: nibble 0, err bit set.
- rescan: a pulse sets rescan_pending. The flag is cleared on the handshake that delivers a frame.
- FSM state SETTLE:
  - out_valid=0.
  - When the frame is stable and (prev frame != last_delivered or rescan_pending): latch out_data, out_blank and out_err from the decode, then go to PRESENT.
- FSM state PRESENT:
  - out_valid=1.
  - out_data, out_blank and out_err are held constant regardless of input changes.
  - On out_valid & out_ready: last_delivered <= latched raw frame, clear rescan_pending, go to SETTLE. out_valid=0 the following cycle.
  - out_ready while in SETTLE is ignored.
- Latency: all six buses switch at once and then hold. The new pattern is first captured into s_hex at edge k. out_valid rises after edge k+STABLE_CYCLES.
- A change on any digit before it is stable restarts that digit's count, so glitches shorter than STABLE_CYCLES never produce a frame.
- Input changes during PRESENT keep debouncing. After the handshake, the FSM compares the newly stable frame against last_delivered, so back-to-back frames are possible.
- Blank and illegal frames are still delivered, with their flags set.
- Reset mid-PRESENT: out_valid=0 and state=SETTLE on the next cycle. The held frame is lost and not re-delivered unless it differs from all-blank.

Optional Feature:
- Macro: SEVSEG_CAPTURE_ERRCNT_EN.
- Defined: err_count increments by 1 on each handshake whose out_err != 0. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: no counter logic; err_count is tied to 16'h0000.

Test Plan:
- Reset, then hold HEX0..5=7'h7F for 50 cycles -> out_valid stays 0 (matches last_delivered).
- HEX0..5 = patterns for 1,2,3,4,5,6, out_ready=0 -> out_valid=1 after edge k+4. out_data=24'h654321, out_err=0, out_blank=0, held for 10 cycles. Assert out_ready -> one transfer, then no re-issue.
- HEX2 toggles to the pattern for 8 for 2 cycles, then returns (STABLE_CYCLES=4) -> no frame delivered.
- HEX3=7'b0101010, others 0 -> out_err=6'b001000, out_data=24'h000000. With the macro defined, err_count=1 after the handshake.
- After a delivered frame, inputs unchanged, pulse rescan -> same frame delivered once more, then idle.
- Assert reset during PRESENT -> out_valid=0 on the next cycle. After release with the same inputs held, the frame is re-delivered after edge k+4.
